// File: rtl/vu_meter_multich.sv
// Multi-channel VU meter: per-channel leaky level, peak-hold bar/dot LEDs and sticky clip flags.
// Level is updated 1 cycle after accept and LEDs refresh once per tick; s_ready_o drops for 2 cycles after each accept.
module vu_meter_multich #(
  parameter int              NUM_CH          = 2,
  parameter int              DATA_W          = 24,
  parameter int              LEVEL_W         = 32,
  parameter int              NUM_LEDS        = 8,
  parameter int              DECAY_SHIFT     = 11,
  parameter int              SCALE_SHIFT     = 12,
  parameter longint unsigned TH_BASE         = 1000,
  parameter int              TH_LOG_STEP     = 1,
  parameter int              LED_DIV         = 540000,
  parameter int              PEAK_HOLD_TICKS = 25,
  parameter longint unsigned CLIP_LEVEL      = (64'd1 << (DATA_W-1)) - 64'd1,
  localparam int             CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_W-1:0]     s_data_i,
  input  logic [CH_W-1:0]              s_ch_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic                         mode_i,
  input  logic                         clip_clr_i,
  output logic [NUM_CH*NUM_LEDS-1:0]   leds_o,
  output logic [NUM_CH-1:0]            clip_o
);

  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam int HW = (PEAK_HOLD_TICKS > 0) ? $clog2(PEAK_HOLD_TICKS + 1) : 1;
  localparam int DW = $clog2(LED_DIV);

  logic [LEVEL_W-1:0]        level_q [NUM_CH];
  logic [PW-1:0]             peak_q  [NUM_CH];
  logic [HW-1:0]             hold_q  [NUM_CH];
  logic [PW-1:0]             peak_n  [NUM_CH];
  logic [HW-1:0]             hold_n  [NUM_CH];
  logic [PW-1:0]             bar_w   [NUM_CH];
  logic [NUM_CH*NUM_LEDS-1:0] leds_q, leds_n;
  logic [NUM_CH-1:0]         clip_q;
  logic [DW-1:0]             div_q;
  logic                      ready_q, gap_q;
  logic                      acc, tick, clip_hit;
  logic [DATA_W-1:0]         mag;

  function automatic logic [63:0] th(input int k);
    return TH_BASE << (k * TH_LOG_STEP);
  endfunction

  // Saturating leaky integrator; the extra top bit catches overflow.
  function automatic logic [LEVEL_W-1:0] next_level(input logic [LEVEL_W-1:0] lvl,
                                                     input logic [DATA_W-1:0]  m);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, lvl - (lvl >> DECAY_SHIFT)} + (LEVEL_W+1)'(m >> SCALE_SHIFT);
    return sum[LEVEL_W] ? '1 : sum[LEVEL_W-1:0];
  endfunction

  assign acc       = s_valid_i & ready_q;
  assign tick      = (div_q == DW'(LED_DIV - 1));
  assign mag       = s_data_i[DATA_W-1] ? (~s_data_i + DATA_W'(1)) : s_data_i;
  assign clip_hit  = (64'(mag) >= CLIP_LEVEL);
  assign s_ready_o = ready_q;
  assign leds_o    = leds_q;
  assign clip_o    = clip_q;

  always_comb begin
    leds_n = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bar_w[c]  = '0;
      peak_n[c] = peak_q[c];
      hold_n[c] = hold_q[c];
      for (int k = 0; k < NUM_LEDS; k++)
        if (64'(level_q[c]) > th(k)) bar_w[c] = bar_w[c] + PW'(1);
      if (bar_w[c] >= peak_q[c]) begin
        peak_n[c] = bar_w[c];
        hold_n[c] = HW'(PEAK_HOLD_TICKS);
      end else if (hold_q[c] != '0) begin
        hold_n[c] = hold_q[c] - HW'(1);
      end else if (peak_q[c] != '0) begin
        peak_n[c] = peak_q[c] - PW'(1);
      end
      // peak LED is index peak-1, compared as k+1 to avoid underflow at 0
      for (int k = 0; k < NUM_LEDS; k++) begin
        if (mode_i)
          leds_n[c*NUM_LEDS + k] = (int'(bar_w[c]) == k + 1) || (int'(peak_n[c]) == k + 1);
        else
          leds_n[c*NUM_LEDS + k] = (k < int'(bar_w[c])) || (int'(peak_n[c]) == k + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        level_q[c] <= '0;
        peak_q[c]  <= '0;
        hold_q[c]  <= '0;
      end
      leds_q  <= '0;
      clip_q  <= '0;
      div_q   <= '0;
      ready_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      if (acc) begin
        ready_q <= 1'b0;
        gap_q   <= 1'b1;
      end else if (gap_q) begin
        gap_q   <= 1'b0;
      end else begin
        ready_q <= 1'b1;
      end
      div_q <= tick ? '0 : div_q + DW'(1);
      // Out-of-range channel tags match no c, so the sample is simply consumed.
      for (int c = 0; c < NUM_CH; c++) begin
        if (acc && (32'(s_ch_i) == c)) level_q[c] <= next_level(level_q[c], mag);
        if (acc && (32'(s_ch_i) == c) && clip_hit) clip_q[c] <= 1'b1;
        else if (clip_clr_i)                        clip_q[c] <= 1'b0;
      end
      if (tick) begin
        peak_q <= peak_n;
        hold_q <= hold_n;
        leds_q <= leds_n;
      end
    end
  end

endmodule

// File: tb/tb_vu_meter_multich.sv
// Directed bench for vu_meter_multich: handshake, level/bar, clip, peak-hold and display modes.
module tb_vu_meter_multich;

  localparam int LED_DIV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_data;
  logic [0:0]  s_ch;
  logic        s_valid;
  logic        s_ready;
  logic        mode;
  logic        clip_clr;
  logic [15:0] leds;
  logic [1:0]  clip;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accepts  = 0;

  vu_meter_multich #(
    .NUM_CH(2), .NUM_LEDS(8), .LED_DIV(LED_DIV), .PEAK_HOLD_TICKS(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_ch_i(s_ch),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .mode_i(mode),
    .clip_clr_i(clip_clr), .leds_o(leds), .clip_o(clip)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; the display refreshes when this hits a multiple of LED_DIV.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_wait();
    int n = 0;
    do begin
      step();
      n++;
    end while ((cyc % LED_DIV) != 0 && n < 40);
  endtask

  task automatic send(input logic [0:0] ch, input logic [23:0] d);
    s_ch    = ch;
    s_data  = d;
    s_valid = 1'b1;
    for (int n = 0; n < 20 && !s_ready; n++) step();
    if (!s_ready) check("send_ready_timeout", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_ch = '0; s_valid = 1'b0; mode = 1'b0; clip_clr = 1'b0;

    // Reset state and ready release
    step();
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_leds",  32'(leds),    32'd0);
    check("rst_clip",  32'(clip),    32'd0);
    rst = 1'b0;
    step();
    check("rel_ready", 32'(s_ready), 32'd1);

    // Back-to-back valid: ready pattern 1,0,0 and 10 accepts in 30 cycles
    s_ch = 1'b0; s_data = 24'h0; s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      check($sformatf("rdy_pat%0d", i), 32'(s_ready), 32'((i % 3) == 0));
      if (s_ready) accepts++;
      step();
    end
    s_valid = 1'b0;
    check("accepts_30cyc", 32'(accepts), 32'd10);

    // Full-scale ch0 sample accepted on the tick edge: tick sees the old level
    repeat (3) step();
    for (int n = 0; n < 20 && (cyc % LED_DIV) != LED_DIV - 1; n++) step();
    check("align_ready", 32'(s_ready), 32'd1);
    s_ch = 1'b0; s_data = 24'h7FFFFF; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("tick_pre_update_leds", 32'(leds), 32'h0000);
    check("clip_ch0_set",         32'(clip), 32'h1);
    // level 2047 > TH0=1000, > TH1=2000 -> bar 2
    tick_wait();
    check("ch0_bar2_leds", 32'(leds), 32'h0003);

    // ch1 hammered with the most negative code -> full bar, clip
    for (int i = 0; i < 100; i++) send(1'b1, 24'h800000);
    tick_wait();
    check("ch1_full_leds", 32'(leds), 32'hFF03);
    check("ch1_clip",      32'(clip), 32'h3);
    clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    check("clip_clear", 32'(clip), 32'h0);
    step();
    check("setwin_ready", 32'(s_ready), 32'd1);
    s_ch = 1'b1; s_data = 24'h800000; s_valid = 1'b1; clip_clr = 1'b1;
    step();
    s_valid = 1'b0; clip_clr = 1'b0;
    check("clip_set_wins", 32'(clip), 32'h2);

    // Reset mid-stream with a sample in flight
    rst = 1'b1; s_ch = 1'b1; s_data = 24'h800000; s_valid = 1'b1;
    step();
    check("mid_rst_ready", 32'(s_ready), 32'd0);
    check("mid_rst_leds",  32'(leds),    32'd0);
    check("mid_rst_clip",  32'(clip),    32'd0);
    rst = 1'b0; s_valid = 1'b0;
    step();
    check("mid_rel_ready", 32'(s_ready), 32'd1);
    tick_wait();
    check("mid_rst_level0_leds", 32'(leds), 32'h0000);
    check("mid_rst_clip_after",  32'(clip), 32'h0);

    // ch0 level: 2048,4095,6142,8188,10233,12277,14320 then +1691 -> 16005 (bar 5)
    for (int i = 0; i < 7; i++) send(1'b0, 24'h800000);
    send(1'b0, 24'h69B000);
    tick_wait();
    check("ch0_bar5_leds", 32'(leds), 32'h001F);
    check("ch0_clip",      32'(clip), 32'h1);
    // one zero sample: 16005 - 7 = 15998 -> bar 4, peak 5 held
    send(1'b0, 24'h000000);
    tick_wait();
    check("hold1_bar_leds", 32'(leds), 32'h001F);
    mode = 1'b1;
    tick_wait();
    check("hold2_dot_leds", 32'(leds), 32'h0018);
    mode = 1'b0;
    tick_wait();
    check("peak_drop_bar_leds", 32'(leds), 32'h000F);
    mode = 1'b1;
    tick_wait();
    check("peak_eq_bar_dot_leds", 32'(leds), 32'h0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
